// File: rtl/mdu_pkg.sv
// Op codes, FSM encoding and default latencies shared by mul_div_unit and mdu_arith.
// MDU_MACC_EN adds the multiply-accumulate ops to the multiply class.
package mdu_pkg;

  localparam int MD_OP_W = 4;
  typedef logic [MD_OP_W-1:0] md_op_t;

  localparam md_op_t OP_NONE  = 4'd0;
  localparam md_op_t OP_MULT  = 4'd1;
  localparam md_op_t OP_MULTU = 4'd2;
  localparam md_op_t OP_DIV   = 4'd3;
  localparam md_op_t OP_DIVU  = 4'd4;
  localparam md_op_t OP_MTHI  = 4'd5;
  localparam md_op_t OP_MTLO  = 4'd6;
  localparam md_op_t OP_MADD  = 4'd7;
  localparam md_op_t OP_MADDU = 4'd8;
  localparam md_op_t OP_MSUB  = 4'd9;
  localparam md_op_t OP_MSUBU = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic logic op_is_mul(input md_op_t op);
`ifdef MDU_MACC_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  function automatic logic op_is_div(input md_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the pending HI/LO and a write enable.
// Zero latency; no flow control. MDU_MACC_EN adds the HI/LO accumulate inputs.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
`ifdef MDU_MACC_EN
  input  logic [WIDTH-1:0]   i_hi,
  input  logic [WIDTH-1:0]   i_lo,
`endif
  input  logic [MD_OP_W-1:0] i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo,
  output logic               o_wr
);

  localparam int W2 = 2 * WIDTH;

  logic             w_sgn;
  logic             w_a_neg, w_b_neg;
  logic [W2-1:0]    w_a_ext, w_b_ext, w_prod;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_divisor, w_q_mag, w_r_mag, w_q, w_r;

  always_comb begin
    w_sgn = (i_op == OP_MULT) || (i_op == OP_DIV);
`ifdef MDU_MACC_EN
    w_sgn = w_sgn || (i_op == OP_MADD) || (i_op == OP_MSUB);
`endif
  end

  // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both signednesses.
  assign w_a_ext = {{WIDTH{w_sgn & i_a[WIDTH-1]}}, i_a};
  assign w_b_ext = {{WIDTH{w_sgn & i_b[WIDTH-1]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Magnitude divide then re-sign: truncates toward zero and MIN/-1 yields MIN, 0.
  assign w_a_neg   = w_sgn & i_a[WIDTH-1];
  assign w_b_neg   = w_sgn & i_b[WIDTH-1];
  assign w_a_mag   = w_a_neg ? -i_a : i_a;
  assign w_b_mag   = w_b_neg ? -i_b : i_b;
  assign w_divisor = (i_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
  assign w_q_mag   = w_a_mag / w_divisor;
  assign w_r_mag   = w_a_mag % w_divisor;
  assign w_q       = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_r       = w_a_neg ? -w_r_mag : w_r_mag;

  always_comb begin
    o_hi = '0;
    o_lo = '0;
    o_wr = 1'b0;
    case (i_op)
      OP_MULT, OP_MULTU: begin
        {o_hi, o_lo} = w_prod;
        o_wr         = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        o_hi = w_r;
        o_lo = w_q;
        o_wr = (i_b != '0);
      end
`ifdef MDU_MACC_EN
      OP_MADD, OP_MADDU: begin
        {o_hi, o_lo} = {i_hi, i_lo} + w_prod;
        o_wr         = 1'b1;
      end
      OP_MSUB, OP_MSUBU: begin
        {o_hi, o_lo} = {i_hi, i_lo} - w_prod;
        o_wr         = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO; MDU_MACC_EN enables MADD/MSUB ops.
// Latency MULT_CYCLES/DIV_CYCLES (MTHI/MTLO 1 edge); E_busy stalls issue, starts while busy are dropped.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               E_start,
  input  logic [MD_OP_W-1:0] E_md_op,
  input  logic [WIDTH-1:0]   E_A,
  input  logic [WIDTH-1:0]   E_B,
  output logic               E_busy,
  output logic [WIDTH-1:0]   HI,
  output logic [WIDTH-1:0]   LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mdu_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;
  logic             r_pend_wr, w_res_wr;
  logic             w_load, w_commit, w_mthi, w_mtlo;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
`ifdef MDU_MACC_EN
    .i_hi (r_hi),
    .i_lo (r_lo),
`endif
    .i_op (E_md_op),
    .i_a  (E_A),
    .i_b  (E_B),
    .o_hi (w_res_hi),
    .o_lo (w_res_lo),
    .o_wr (w_res_wr)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (E_start) begin
          if (op_is_mul(E_md_op)) begin
            w_load      = 1'b1;
            w_cnt_nxt   = MULT_LD;
            w_state_nxt = ST_RUN;
          end else if (op_is_div(E_md_op)) begin
            w_load      = 1'b1;
            w_cnt_nxt   = DIV_LD;
            w_state_nxt = ST_RUN;
          end else begin
            w_mthi = (E_md_op == OP_MTHI);
            w_mtlo = (E_md_op == OP_MTLO);
          end
        end
      end
      ST_RUN: begin
        // Count is loaded with N, so the commit edge is exactly N edges after the start edge.
        if (r_cnt <= CNT_ONE) begin
          w_commit    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_pend_wr <= w_res_wr;
      end
      if (w_commit && r_pend_wr) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if (w_mthi) r_hi <= E_A;
      if (w_mtlo) r_lo <= E_A;
    end
  end

  assign E_busy = (r_state == ST_RUN);
  assign HI     = r_hi;
  assign LO     = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO and busy length queued at issue, checked at completion.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, E_start, E_busy;
  logic [3:0]  E_md_op;
  logic [31:0] E_A, E_B, HI, LO;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .E_start (E_start),
    .E_md_op (E_md_op),
    .E_A     (E_A),
    .E_B     (E_B),
    .E_busy  (E_busy),
    .HI      (HI),
    .LO      (LO)
  );

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after E_busy has fallen.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input int lat);
    exp_t        e;
    int          n;
    logic [31:0] old_hi, old_lo;
    e.tag = tag; e.hi = hi; e.lo = lo; e.lat = lat;
    sb.push_back(e);
    old_hi  = HI;
    old_lo  = LO;
    E_md_op = op; E_A = a; E_B = b; E_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    E_start = 1'b0; E_md_op = OP_NONE;
    n = 0;
    while (E_busy && n < 200) begin
      n++;
      if (n == 1) check_eq({tag, " hold"}, {HI, LO}, {old_hi, old_lo});
      @(negedge clk);
    end
    e = sb.pop_front();
    check_eq({e.tag, " busy"}, 64'(n), 64'(e.lat));
    check_eq({e.tag, " HI"}, {32'h0, HI}, {32'h0, e.hi});
    check_eq({e.tag, " LO"}, {32'h0, LO}, {32'h0, e.lo});
  endtask

  initial begin
    int          n;
    logic [31:0] a, b;
    longint      p;
    logic [63:0] up;
    int          q, r;

    reset = 1'b1; E_start = 1'b0; E_md_op = OP_NONE; E_A = '0; E_B = '0;
    repeat (2) @(negedge clk);
    check_eq("rst busy", {63'h0, E_busy}, 64'h0);
    check_eq("rst HILO", {HI, LO}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    issue("mult",  OP_MULT,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    issue("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    issue("div",   OP_DIV,   -32'sd7,       32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue("divu",  OP_DIVU,  32'd7,         32'd2, 32'd1,         32'd3,         10);
    issue("divmin", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);
    issue("mthi",  OP_MTHI,  32'h11, 32'h0, 32'h11, 32'h8000_0000, 0);
    issue("mtlo",  OP_MTLO,  32'h22, 32'h0, 32'h11, 32'h22, 0);
    issue("div0",  OP_DIV,   32'd5,  32'd0, 32'h11, 32'h22, 10);
    issue("nop15", 4'd15,    32'h99, 32'h3, 32'h11, 32'h22, 0);

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      case (i % 4)
        0: begin
          p = longint'($signed(a)) * longint'($signed(b));
          issue("rmult", OP_MULT, a, b, p[63:32], p[31:0], 5);
        end
        1: begin
          up = {32'h0, a} * {32'h0, b};
          issue("rmultu", OP_MULTU, a, b, up[63:32], up[31:0], 5);
        end
        2: begin
          b = (i < 4) ? 32'($urandom_range(1, 1000)) : (b | 32'h1);
          issue("rdivu", OP_DIVU, a, b, a % b, a / b, 10);
        end
        default: begin
          a = {1'b0, a[30:0]} - 32'h4000_0000;
          b = 32'($signed(32'($urandom_range(1, 200))) - 100);
          if (b == 0) b = 32'd3;
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          issue("rdiv", OP_DIV, a, b, r, q, 10);
        end
      endcase
    end

    // Starts during RUN (MULT, then MTLO) must neither restart nor disturb the DIV.
    sb.push_back('{"ignore", 32'd2, 32'd14, 10});
    E_md_op = OP_DIV; E_A = 32'd100; E_B = 32'd7; E_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    E_start = 1'b0;
    n = 0;
    while (E_busy && n < 200) begin
      n++;
      E_start = (n == 2) || (n == 4);
      E_md_op = (n == 2) ? OP_MULT : OP_MTLO;
      E_A = 32'hDEAD_BEEF; E_B = 32'd3;
      @(negedge clk);
    end
    E_start = 1'b0; E_md_op = OP_NONE;
    begin
      exp_t e;
      e = sb.pop_front();
      check_eq({e.tag, " busy"}, 64'(n), 64'(e.lat));
      check_eq({e.tag, " HILO"}, {HI, LO}, {e.hi, e.lo});
    end

    // Reset in the middle of a divide discards the pending result.
    E_md_op = OP_DIVU; E_A = 32'd50; E_B = 32'd3; E_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    E_start = 1'b0;
    n = 1;
    while (E_busy && n < 3) begin
      n++;
      @(negedge clk);
    end
    check_eq("midrst busy before", {63'h0, E_busy}, 64'h1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst busy", {63'h0, E_busy}, 64'h0);
    check_eq("midrst HILO", {HI, LO}, 64'h0);
    repeat (12) @(negedge clk);
    check_eq("midrst discard", {HI, LO}, 64'h0);
    check_eq("midrst idle", {63'h0, E_busy}, 64'h0);

    issue("mthi0", OP_MTHI, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    issue("mtlo5", OP_MTLO, 32'h5, 32'h0, 32'h0, 32'h5, 0);
`ifdef MDU_MACC_EN
    issue("madd",  OP_MADD,  32'd2, 32'd3, 32'h0,         32'd11,        5);
    issue("msubu", OP_MSUBU, 32'd4, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 5);
`else
    issue("madd",  OP_MADD,  32'd2, 32'd3, 32'h0, 32'd5, 0);
    issue("msubu", OP_MSUBU, 32'd4, 32'd4, 32'h0, 32'd5, 0);
`endif
    issue("b2b", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
